// File: rtl/noobs_mem_arbiter_if.sv
// noobs_mem_arbiter_if: requester-side request/response bus plus the single-port memory command bus
interface noobs_mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
);
  logic [NUM_PORTS-1:0]        req_vld;
  logic [NUM_PORTS-1:0]        req_wr;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_rdy;
  logic [NUM_PORTS-1:0]        rsp_vld;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        m_en;
  logic                        m_rd;
  logic                        m_wr;
  logic [ADDR_W-1:0]           m_addr;
  logic [DATA_W-1:0]           m_wr_data;
  logic [DATA_W-1:0]           m_rd_data;
  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, m_rd_data,
    output req_rdy, rsp_vld, rsp_rdata, m_en, m_rd, m_wr, m_addr, m_wr_data
  );
  modport master (
    output req_vld, req_wr, req_addr, req_wdata, m_rd_data,
    input  req_rdy, rsp_vld, rsp_rdata, m_en, m_rd, m_wr, m_addr, m_wr_data
  );
endinterface

// File: rtl/noobs_mem_arbiter.sv
// noobs_mem_arbiter: fixed-priority or round-robin arbiter sharing one pipelined synchronous memory
module noobs_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int ARB_MODE   = 0
) (
  input  logic                clk,
  input  logic                reset_,
  noobs_mem_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NUM_PORTS);
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d, start, g_hi, g_lo, gnt_idx;
  logic                  f_hi, f_lo, gnt;
  logic                  m_en_q, m_en_d, m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic [PW-1:0]         cmd_idx_q, cmd_idx_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [PW-1:0]         tag_idx_q [RD_LATENCY];
  logic [PW-1:0]         tag_idx_d [RD_LATENCY];
  assign start = ARB_MODE == 1 ? rr_ptr_q : '0;
  always_comb begin
    f_hi = 1'b0;
    f_lo = 1'b0;
    g_hi = '0;
    g_lo = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (bus.req_vld[j]) begin
        f_lo = 1'b1;
        g_lo = PW'(j);
      end
      if (bus.req_vld[j] && PW'(j) >= start) begin
        f_hi = 1'b1;
        g_hi = PW'(j);
      end
    end
  end
  assign gnt_idx     = f_hi ? g_hi : g_lo;
  assign gnt         = f_lo & reset_;
  assign bus.req_rdy = gnt ? NUM_PORTS'(1) << gnt_idx : '0;
  always_comb begin
    m_en_d    = gnt;
    m_rd_d    = gnt & ~bus.req_wr[gnt_idx];
    m_wr_d    = gnt & bus.req_wr[gnt_idx];
    m_addr_d  = gnt ? bus.req_addr[gnt_idx*ADDR_W +: ADDR_W] : m_addr_q;
    m_wdata_d = gnt ? bus.req_wdata[gnt_idx*DATA_W +: DATA_W] : m_wdata_q;
    cmd_idx_d = gnt ? gnt_idx : cmd_idx_q;
    rr_ptr_d  = (ARB_MODE == 1 && gnt) ? (gnt_idx == PW'(NUM_PORTS - 1) ? '0 : gnt_idx + PW'(1)) : rr_ptr_q;
  end
  // tags are fed from the command register, so the final stage lines up with the memory's read data
  always_comb begin
    tag_vld_d[0] = m_rd_q;
    tag_idx_d[0] = cmd_idx_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_en_q    <= 1'b0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      cmd_idx_q <= '0;
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '{default: '0};
    end else begin
      m_en_q    <= m_en_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      cmd_idx_q <= cmd_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end
  assign bus.m_en      = m_en_q;
  assign bus.m_rd      = m_rd_q;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wr_data = m_wdata_q;
  assign bus.rsp_vld   = tag_vld_q[RD_LATENCY-1] ? NUM_PORTS'(1) << tag_idx_q[RD_LATENCY-1] : '0;
  assign bus.rsp_rdata = bus.m_rd_data;
endmodule
